bit_frame_checker: RTL and testbench

BIT_FRAME_CHECKER -- requirements
Module: bit_frame_checker

---
 rtl/bit_frame_checker_if.sv | 25 ++
 rtl/bit_frame_checker.sv | 75 +++++++
 tb/tb_bit_frame_checker.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/bit_frame_checker_if.sv
// Handshake bundle for bit_frame_checker: beat input side and frame-result side.
// The master drives beats and out_ready; the slave (the checker) drives ready/result.
interface bit_frame_checker_if;
   logic       in_valid;
   logic       a;
   logic       b;
   logic       abort;
   logic       in_ready;
   logic       out_valid;
   logic       out_ready;
   logic       out_equal;
   logic [3:0] out_mism;
   logic [3:0] out_first;
   logic [3:0] out_max_run;

   modport master (
      output in_valid, a, b, abort, out_ready,
      input  in_ready, out_valid, out_equal, out_mism, out_first, out_max_run
   );

   modport slave (
      input  in_valid, a, b, abort, out_ready,
      output in_ready, out_valid, out_equal, out_mism, out_first, out_max_run
   );
endinterface

// File: rtl/bit_frame_checker.sv
// Compares LEN a/b bit pairs per frame and reports equality, mismatch count,
// first mismatch index and the longest run of equal pairs, held until taken.
module bit_frame_checker #(
   parameter int LEN = 8
) (
   input logic              clk,
   input logic              reset,
   bit_frame_checker_if.slave bus
);

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] COLLECT = 2'd1;
   localparam logic [1:0] HOLD    = 2'd2;
   localparam logic [3:0] LAST    = 4'(LEN - 1);
   localparam logic [3:0] NONE    = 4'hF;

   logic [1:0] state;
   logic [3:0] idx;
   logic [3:0] mism;
   logic [3:0] first;
   logic [3:0] run;
   logic [3:0] max_run;

   logic eq;
   logic clear_acc;
   logic [3:0] run_inc;

   function automatic logic [3:0] max4(input logic [3:0] x, input logic [3:0] y);
      return (x > y) ? x : y;
   endfunction

   assign eq      = (bus.a == bus.b);
   assign run_inc = run + 4'd1;

   // Abort is honoured only while collecting; in HOLD only the handshake frees the result.
   assign clear_acc = ((state != HOLD) && bus.abort) ||
                      ((state == HOLD) && bus.out_ready);

   always_ff @(posedge clk) begin
      if (reset || clear_acc) begin
         state   <= IDLE;
         idx     <= 4'd0;
         mism    <= 4'd0;
         first   <= NONE;
         run     <= 4'd0;
         max_run <= 4'd0;
      end else if ((state != HOLD) && bus.in_valid) begin
         idx <= idx + 4'd1;
         if ((state == COLLECT) && (idx == LAST)) begin
            state <= HOLD;
         end else begin
            state <= COLLECT;
         end
         if (eq) begin
            run     <= run_inc;
            max_run <= max4(max_run, run_inc);
         end else begin
            run  <= 4'd0;
            mism <= mism + 4'd1;
            // idx never reaches 4'hF, so NONE doubles as "not yet latched".
            if (first == NONE) begin
               first <= idx;
            end
         end
      end
   end

   assign bus.in_ready    = (state != HOLD);
   assign bus.out_valid   = (state == HOLD);
   assign bus.out_equal   = (mism == 4'd0);
   assign bus.out_mism    = mism;
   assign bus.out_first   = first;
   assign bus.out_max_run = max_run;

endmodule

// File: tb/tb_bit_frame_checker.sv
// Directed bench for bit_frame_checker: a list-based frame model checked every
// cycle, plus literal expectations for the hand-worked scenarios.
module tb_bit_frame_checker;
   localparam int LEN = 8;

   logic clk = 1'b0;
   logic reset;
   int   n_checks = 0;
   int   n_fail   = 0;
   bit   check_en = 1'b0;

   bit_frame_checker_if bus ();

   bit_frame_checker #(.LEN(LEN)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Model: the frame is the list of per-beat equality flags accepted so far.
   bit m_bits[$];
   bit m_hold = 1'b0;

   always @(posedge clk) begin
      if (reset) begin
         m_bits.delete();
         m_hold = 1'b0;
      end else if (m_hold) begin
         if (bus.out_ready) begin
            m_bits.delete();
            m_hold = 1'b0;
         end
      end else if (bus.abort) begin
         m_bits.delete();
      end else if (bus.in_valid) begin
         m_bits.push_back(bus.a == bus.b);
         if (m_bits.size() == LEN) m_hold = 1'b1;
      end
   end

   always @(negedge clk) begin
      if (check_en) begin
         int mm, ff, cur, best;
         mm = 0; ff = 15; cur = 0; best = 0;
         foreach (m_bits[i]) begin
            if (!m_bits[i]) begin
               mm++;
               if (ff == 15) ff = i;
               cur = 0;
            end else begin
               cur++;
               if (cur > best) best = cur;
            end
         end
         chk("model in_ready", int'(bus.in_ready), int'(!m_hold));
         chk("model out_valid", int'(bus.out_valid), int'(m_hold));
         chk("model out_equal", int'(bus.out_equal), int'(mm == 0));
         chk("model out_mism", int'(bus.out_mism), mm);
         chk("model out_first", int'(bus.out_first), ff);
         chk("model out_max_run", int'(bus.out_max_run), best);
      end
   end

   task automatic step();
      @(negedge clk);
   endtask

   task automatic beat(input logic av, input logic bv);
      bus.in_valid = 1'b1; bus.a = av; bus.b = bv;
      step();
      bus.in_valid = 1'b0;
   endtask

   task automatic expect_result(input string name, input int eq, input int mm,
                                input int ff, input int mr);
      int waited = 0;
      while (!bus.out_valid && waited < 40) begin
         step();
         waited++;
      end
      chk({name, " result arrives"}, int'(bus.out_valid), 1);
      chk({name, " equal"}, int'(bus.out_equal), eq);
      chk({name, " mism"}, int'(bus.out_mism), mm);
      chk({name, " first"}, int'(bus.out_first), ff);
      chk({name, " max_run"}, int'(bus.out_max_run), mr);
   endtask

   task automatic take_result(input string name);
      bus.out_ready = 1'b1;
      step();
      bus.out_ready = 1'b0;
      chk({name, " in_ready after take"}, int'(bus.in_ready), 1);
      chk({name, " out_valid after take"}, int'(bus.out_valid), 0);
   endtask

   initial begin
      reset = 1'b1;
      bus.in_valid = 1'b0; bus.a = 1'b0; bus.b = 1'b0;
      bus.abort = 1'b0; bus.out_ready = 1'b0;
      step(); step();
      reset = 1'b0;
      check_en = 1'b1;

      // Reset state
      chk("rst in_ready", int'(bus.in_ready), 1);
      chk("rst out_valid", int'(bus.out_valid), 0);
      chk("rst out_equal", int'(bus.out_equal), 1);
      chk("rst out_mism", int'(bus.out_mism), 0);
      chk("rst out_first", int'(bus.out_first), 15);
      chk("rst out_max_run", int'(bus.out_max_run), 0);

      // All-equal frame consumed immediately
      bus.out_ready = 1'b1;
      for (int i = 0; i < LEN; i++) beat(i[0], i[0]);
      expect_result("eq8", 1, 0, 15, 8);
      step();
      chk("eq8 back to idle", int'(bus.in_ready), 1);
      chk("eq8 no valid", int'(bus.out_valid), 0);
      bus.out_ready = 1'b0;

      // Mismatches at idx 2 and 5, then a long stall with noise and abort in HOLD
      for (int i = 0; i < LEN; i++) beat(1'b1, !(i == 2 || i == 5));
      expect_result("mm25", 0, 2, 2, 2);
      for (int i = 0; i < 5; i++) begin
         bus.in_valid = i[0]; bus.a = i[1]; bus.b = !i[1];
         bus.abort = (i == 2);
         step();
         chk("hold in_ready", int'(bus.in_ready), 0);
         chk("hold out_valid", int'(bus.out_valid), 1);
         chk("hold mism", int'(bus.out_mism), 2);
         chk("hold first", int'(bus.out_first), 2);
         chk("hold max_run", int'(bus.out_max_run), 2);
      end
      bus.in_valid = 1'b0; bus.abort = 1'b0;
      take_result("mm25");

      // Partial frame aborted (with a coincident beat), then a clean frame
      for (int i = 0; i < 4; i++) beat(1'b0, (i == 1));
      bus.abort = 1'b1; bus.in_valid = 1'b1; bus.a = 1'b1; bus.b = 1'b0;
      step();
      bus.abort = 1'b0; bus.in_valid = 1'b0;
      chk("abort clears mism", int'(bus.out_mism), 0);
      chk("abort clears first", int'(bus.out_first), 15);
      for (int i = 0; i < LEN; i++) beat(1'b0, 1'b0);
      expect_result("abort", 1, 0, 15, 8);
      take_result("abort");

      // Gapped frame, last pair mismatching
      for (int i = 0; i < LEN; i++) begin
         beat(1'b1, (i != 7));
         if (i != LEN - 1) repeat (3) step();
      end
      expect_result("gaps", 0, 1, 7, 7);
      take_result("gaps");

      // Reset mid-frame (with a coincident beat), then a clean frame
      for (int i = 0; i < 5; i++) beat(1'b0, 1'b1);
      reset = 1'b1; bus.in_valid = 1'b1; bus.a = 1'b1; bus.b = 1'b1;
      step();
      reset = 1'b0; bus.in_valid = 1'b0;
      chk("midrst mism", int'(bus.out_mism), 0);
      for (int i = 0; i < LEN; i++) beat(1'b1, 1'b1);
      expect_result("midrst", 1, 0, 15, 8);

      // Reset while holding a result
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("hold rst out_valid", int'(bus.out_valid), 0);
      chk("hold rst in_ready", int'(bus.in_ready), 1);
      chk("hold rst max_run", int'(bus.out_max_run), 0);

      step(); step();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end
endmodule
